cmp_stb_sampler: RTL

//  Sits between the strobe generator (hclk domain) and the skew-measurement

---
 rtl/cmp_stb_sampler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cmp_stb_sampler.sv
// Strobe-driven comparator sampler: issues N strobe requests, waits for each
// synchronized strobe_valid edge, lets the comparator settle, then counts hits.
module cmp_stb_sampler #(
    parameter int N_W            = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           run_i,
    input  logic [N_W-1:0] n_samples_i,
    output logic           stb_req_o,
    input  logic           stb_valid_i,
    input  logic           cmp_i,
    output logic [N_W-1:0] hit_cnt_o,
    output logic           majority_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // WAIT gives up once the next count value would reach TIMEOUT_CYCLES-1,
    // which puts DONE exactly TIMEOUT_CYCLES cycles after the REQ cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    logic [2:0]      r_state;
    logic            r_valid_s1;
    logic            r_valid_s2;
    logic            r_valid_s3;
    logic            r_cmp_s1;
    logic            r_cmp_s2;
    logic [N_W-1:0]  r_n;
    logic [N_W-1:0]  r_hit;
    logic [N_W-1:0]  r_smp;
    logic [TO_W-1:0] r_to_cnt;
    logic [ST_W-1:0] r_set_cnt;
    logic            r_err;
    logic            r_maj;

    logic            w_valid_edge;
    logic [N_W-1:0]  w_hit_next;
    logic [N_W-1:0]  w_smp_next;
    logic            w_maj_next;

    assign w_valid_edge = r_valid_s2 & ~r_valid_s3;
    assign w_hit_next   = (r_cmp_s2 && (r_hit != '1)) ? r_hit + N_W'(1) : r_hit;
    assign w_smp_next   = r_smp + N_W'(1);
    assign w_maj_next   = ({w_hit_next, 1'b0} > {1'b0, r_n});

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
            r_valid_s3 <= 1'b0;
            r_cmp_s1   <= 1'b0;
            r_cmp_s2   <= 1'b0;
        end else begin
            r_valid_s1 <= stb_valid_i;
            r_valid_s2 <= r_valid_s1;
            r_valid_s3 <= r_valid_s2;
            r_cmp_s1   <= cmp_i;
            r_cmp_s2   <= r_cmp_s1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_hit     <= '0;
            r_smp     <= '0;
            r_to_cnt  <= '0;
            r_set_cnt <= '0;
            r_err     <= 1'b0;
            r_maj     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_i) begin
                        if (n_samples_i != '0) begin
                            r_n     <= n_samples_i;
                            r_hit   <= '0;
                            r_smp   <= '0;
                            r_err   <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_hit   <= '0;
                            r_err   <= 1'b1;
                            r_maj   <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_valid_edge) begin
                        r_set_cnt <= '0;
                        r_state   <= S_SETTLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_maj   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_set_cnt == ST_LAST) begin
                        r_hit <= w_hit_next;
                        r_smp <= w_smp_next;
                        if (w_smp_next == r_n) begin
                            r_maj   <= w_maj_next;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else begin
                        r_set_cnt <= r_set_cnt + ST_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stb_req_o  = (r_state == S_REQ);
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign hit_cnt_o  = r_hit;
    assign majority_o = r_maj;
    assign err_o      = r_err;

endmodule
